empacotador_bytes: RTL
======================

Name: empacotador_bytes

Overview:
Upstream stage that packs a byte stream into 32-bit words for the vector-manipulation block.
- Accepts one byte per cycle over a valid/ready handshake.
- Accumulates 4 bytes, then presents the packed word on a registered valid/ready output whose data drives the manipulator's 32-bit `entrada`.
- Supports flushing a partial word, with zero/pad fill and a byte-count tag.

Parameters:
- BYTE_ORDER, 0: byte placement. 0 = first byte to bits [7:0] (little-endian); 1 = first byte to bits [31:24].
- PAD_BYTE, 8'h00: fill value for unused byte lanes on a flushed partial word.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- byte_in  input  8  input byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  block accepts byte_in this cycle.
- flush  input  1  level request: emit pending partial word.
- word_out  output  32  packed word to downstream (`entrada` of the manipulator).
- word_valid  output  1  word_out holds a valid word.
- word_ready  input  1  downstream accepts word_out this cycle.
- word_bytes  output  3  number of real bytes in word_out, 1..4.

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset, sampled at the rising edge with rst=1, drives these outputs the following cycle:
  - word_out=0, word_valid=0, word_bytes=0.
  - Accumulator cleared, count=0.
  - byte_ready=0 while rst=1.
- Reset mid-word discards any partial bytes and any unaccepted output word.
- Byte acceptance: a byte is taken when byte_valid && byte_ready. Data must not be consumed otherwise.
- Accumulator holds up to 3 bytes; count ranges 0..3.
- Lane placement for the k-th byte (k = 0..3):
  - BYTE_ORDER=0: lane k = bits [8k+7:8k].
  - BYTE_ORDER=1: lane 3-k.
- Output slot has two states, VAZIO and CHEIO.
  - slot_free = VAZIO, or (CHEIO && word_ready).
- byte_ready = !rst && !(count==3 && !slot_free). There is no other stall source.
- Word completion: the byte accepted at count==3 completes the word.
  - In that same cycle, {3 held bytes + incoming byte} is registered into the output slot.
  - Next cycle: word_valid=1, word_bytes=4, count=0.
  - Latency: 4th byte accepted in cycle N gives word_valid in cycle N+1.
- Output drain: on word_valid && word_ready, the slot goes to VAZIO, unless a new word loads in the same cycle; then it stays CHEIO with the new data.
  - word_out and word_bytes are stable while word_valid=1 and word_ready=0.
- Flush acts in a cycle where flush=1, slot_free=1, and the effective count after any same-cycle byte acceptance is 1..3.
  - The partial word loads with unused lanes = PAD_BYTE.
  - word_bytes = effective count; count resets to 0.
- Flush edge cases:
  - Same-cycle byte raises the effective count to 4: a normal full word is emitted and flush has no extra effect.
  - Effective count 0: flush is ignored.
  - Slot not free: flush waits. The requester holds flush until word_valid rises.
- Throughput: with word_ready held at 1, one byte per cycle is sustained indefinitely with byte_ready constantly 1.

Decomposition:
- Shared package contains:
  - BYTE_ORDER_LE=0 and BYTE_ORDER_BE=1 constants.
  - WORD_W=32 and BYTE_W=8.
  - Slot-state encoding VAZIO/CHEIO.
- One natural sub-module: registro_saida, a 1-entry valid/ready output register holding word_out and word_bytes with a load/drain interface.
- Packing and lane logic stay in the top module.

Test Plan:
1. BYTE_ORDER=0, word_ready=1: bytes 01,02,03,04 in consecutive cycles -> word_out=32'h04030201, word_bytes=4, word_valid high for one cycle, one cycle after byte 04.
2. BYTE_ORDER=1: bytes 01,02,03,04 -> word_out=32'h01020304.
3. Back-pressure with word_ready=0: offer bytes 01..08 continuously.
   - Bytes 01..07 accepted; byte_ready=0 while 08 is offered; word_out=32'h04030201 held stable.
   - Raise word_ready for one cycle -> 08 accepted that cycle, then word_out=32'h08070605.
4. Flush, PAD_BYTE=00, BYTE_ORDER=0: bytes AA,BB, then flush=1 -> word_out=32'h0000BBAA, word_bytes=2.
   - Flush with count=0 -> no word_valid.
5. Reset mid-word: bytes 11,22, then rst=1 for one cycle, then 01,02,03,04 -> word_out=32'h04030201, with no trace of 11 or 22.
6. Streaming, word_ready=1: 12 bytes 00..0B back-to-back -> 3 words 03020100, 07060504, 0B0A0908; byte_ready never drops.

Source files
------------

// File: rtl/empacotador_bytes_pkg.sv
// Shared types and constants for the byte-to-word packer.
// The packer feeds the 32-bit input of the vector manipulator.
package empacotador_bytes_pkg;

  localparam int WORD_W        = 32;
  localparam int BYTE_W        = 8;
  localparam int NUM_LANES     = WORD_W / BYTE_W;
  localparam int BYTE_ORDER_LE = 0;
  localparam int BYTE_ORDER_BE = 1;

  typedef enum logic {VAZIO = 1'b0, CHEIO = 1'b1} slot_t;

  typedef struct packed {
    logic [WORD_W-1:0] dados;
    logic [2:0]        nbytes;
  } palavra_t;

  // Lane that receives the k-th byte of a word.
  function automatic int lane_of(input int k, input int order);
    return (order == BYTE_ORDER_BE) ? (NUM_LANES - 1 - k) : k;
  endfunction

endpackage

// File: rtl/empacotador_bytes_registro_saida.sv
// One-entry valid/ready output register.
// Holds a packed word and its byte count until downstream takes it.
module registro_saida
  import empacotador_bytes_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  palavra_t din,
  input  logic     ready,
  output logic     valid,
  output palavra_t dout,
  output logic     slot_free
);

  slot_t estado;

  // A load may coincide with a drain; the new word then replaces the old one.
  assign slot_free = (estado == VAZIO) || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= VAZIO;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      case (estado)
        VAZIO: begin
          if (load) begin
            estado <= CHEIO;
            valid  <= 1'b1;
            dout   <= din;
          end
        end
        CHEIO: begin
          if (load) begin
            dout <= din;
          end else if (ready) begin
            estado <= VAZIO;
            valid  <= 1'b0;
          end
        end
        default: begin
          estado <= VAZIO;
          valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/empacotador_bytes.sv
// Packs a byte stream into 32-bit words, with flush of partial words
// padded by PAD_BYTE and tagged with the real byte count.
module empacotador_bytes
  import empacotador_bytes_pkg::*;
#(
  parameter int          BYTE_ORDER = 0,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              flush,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [2:0]        word_bytes
);

  logic [1:0]                       count;
  logic [2:0][BYTE_W-1:0]           acc;
  logic [NUM_LANES-1:0][BYTE_W-1:0] seq;
  logic [2:0]                       eff_cnt;
  logic                             take, full, do_flush, load, slot_free;
  palavra_t                         nova, saida;

  assign byte_ready = !rst && !(count == 2'd3 && !slot_free);
  assign take       = byte_valid && byte_ready;
  assign eff_cnt    = {1'b0, count} + {2'b00, take};
  assign full       = take && (count == 2'd3);
  // A same-cycle byte that completes the word makes flush redundant.
  assign do_flush   = flush && slot_free && !full && (eff_cnt != 3'd0);
  assign load       = full || do_flush;

  always_comb begin
    logic [BYTE_W-1:0] b;
    b    = '0;
    seq  = {PAD_BYTE, acc[2], acc[1], acc[0]};
    nova = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (3'(k) < {1'b0, count})
        b = seq[k];
      else if (3'(k) == {1'b0, count} && take)
        b = byte_in;
      else
        b = PAD_BYTE;
      nova.dados[lane_of(k, BYTE_ORDER)*BYTE_W +: BYTE_W] = b;
    end
    nova.nbytes = eff_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      acc   <= '0;
    end else if (load) begin
      count <= '0;
    end else if (take) begin
      for (int k = 0; k < 3; k++)
        if (count == 2'(k)) acc[k] <= byte_in;
      count <= count + 2'd1;
    end
  end

  registro_saida u_saida (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .din       (nova),
    .ready     (word_ready),
    .valid     (word_valid),
    .dout      (saida),
    .slot_free (slot_free)
  );

  assign word_out   = saida.dados;
  assign word_bytes = saida.nbytes;

endmodule
